// File: rtl/fp_mul_arbiter_if.sv
// Request, multiplier and response bundle for fp_mul_arbiter.
// The master side is the requester/consumer/multiplier environment; the slave side is the arbiter.
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_x;
    logic [NUM_REQ-1:0][31:0] req_y;
    logic [31:0]              mul_x;
    logic [31:0]              mul_y;
    logic [31:0]              mul_z;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [31:0]              rsp_z;
    logic                     rsp_sat;
    logic [CNT_W-1:0]         sat_count;
    logic                     busy;

    modport master (
        output req_valid, req_x, req_y, mul_z, rsp_ready,
        input  req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_z, rsp_sat, sat_count, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, mul_z, rsp_ready,
        output req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_z, rsp_sat, sat_count, busy
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one external combinational FP multiplier between NUM_REQ requesters,
// with operand register (S1) before and result register (S2) after the multiplier.
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input logic             clk,
    input logic             rst,
    fp_mul_arbiter_if.slave bus
);

    logic [2:1]       vld_pipe;
    logic [ID_W-1:0]  id1, id2;
    logic [31:0]      x1, y1, z2;
    logic             sat2;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic             grant_vld;
    logic             adv1, adv2;
    logic             sat_pat;
    logic [CNT_W-1:0] sat_cnt;

    assign adv2    = !vld_pipe[2] || bus.rsp_ready;
    assign adv1    = adv2 || !vld_pipe[1];
    assign sat_pat = (bus.mul_z[30:23] == 8'hFE) && (&bus.mul_z[22:0]);

    // First valid requester after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_vld && bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Ready is masked during reset so no transfer is signalled that the pipe will not keep.
    always_comb begin
        bus.req_ready = '0;
        if (adv1 && grant_vld && !rst)
            bus.req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            id1      <= '0;
            x1       <= '0;
            y1       <= '0;
            id2      <= '0;
            z2       <= '0;
            sat2     <= 1'b0;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
        end else begin
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                id2         <= id1;
                z2          <= bus.mul_z;
                sat2        <= vld_pipe[1] && sat_pat;
            end
            if (adv1) begin
                vld_pipe[1] <= grant_vld;
                if (grant_vld) begin
                    id1    <= grant_idx;
                    x1     <= bus.req_x[grant_idx];
                    y1     <= bus.req_y[grant_idx];
                    rr_ptr <= grant_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt <= '0;
        else if (vld_pipe[2] && bus.rsp_ready && sat2 && !(&sat_cnt))
            sat_cnt <= sat_cnt + 1'b1;
    end

    assign bus.mul_x     = x1;
    assign bus.mul_y     = y1;
    assign bus.rsp_valid = vld_pipe[2];
    assign bus.rsp_id    = id2;
    assign bus.rsp_z     = z2;
    assign bus.rsp_sat   = sat2;
    assign bus.sat_count = sat_cnt;
    assign bus.busy      = |vld_pipe;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed + random bench for fp_mul_arbiter: scoreboard of grants/results from an
// independent arbitration rule and an approximate multiplier model.
module tb_fp_mul_arbiter;
    localparam int NR = 4;

    logic clk;
    logic rst;

    fp_mul_arbiter_if #(.NUM_REQ(NR), .ID_W(2), .CNT_W(16)) bus ();
    fp_mul_arbiter_if #(.NUM_REQ(2), .ID_W(1), .CNT_W(3)) bus2 ();

    fp_mul_arbiter #(.NUM_REQ(NR), .ID_W(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    fp_mul_arbiter #(.NUM_REQ(2), .ID_W(1), .CNT_W(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        int          id;
        logic [31:0] z;
        logic        sat;
    } exp_t;

    exp_t        q[$];
    int          gnt_log[$];
    int          checks = 0;
    int          errors = 0;
    int          last_grant = NR - 1;
    int          exp_cnt = 0;
    bit          auto_drop = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_z = '0;
    int          prev_id = 0;

    // Mitchell-style approximate multiplier with overflow clamp to the largest finite value.
    function automatic logic [31:0] amul(input logic [31:0] x, input logic [31:0] y);
        int          e;
        logic [23:0] s;
        logic        sg;
        sg = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {sg, 31'b0};
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        s = {1'b0, x[22:0]} + {1'b0, y[22:0]};
        if (s[23]) e++;
        if (e >= 255) return {sg, 8'hFE, 23'h7FFFFF};
        if (e <= 0) return {sg, 31'b0};
        return {sg, e[7:0], s[22:0]};
    endfunction

    function automatic logic is_sat(input logic [31:0] z);
        return (z[30:23] == 8'hFE) && (&z[22:0]);
    endfunction

    assign bus.mul_z  = amul(bus.mul_x, bus.mul_y);
    assign bus2.mul_z = amul(bus2.mul_x, bus2.mul_y);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score handshakes, advance to posedge+1.
    task automatic step();
        int   g;
        exp_t e;
        bit   acc;
        g   = -1;
        acc = 0;
        @(negedge clk);
        chk("sat_count", 32'(bus.sat_count), 32'(exp_cnt));
        if (prev_stall) begin
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_id", 32'(bus.rsp_id), 32'(prev_id));
            chk("hold_z", bus.rsp_z, prev_z);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                chk("rsp_expected", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                chk("rsp_z", bus.rsp_z, e.z);
                chk("rsp_sat", 32'(bus.rsp_sat), 32'(e.sat));
                if (e.sat && exp_cnt < 65535) exp_cnt++;
            end
        end
        if (bus.req_ready != '0) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (last_grant + k) % NR;
                if (g < 0 && bus.req_valid[c]) g = c;
            end
            chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            if (g >= 0) begin
                e.id  = g;
                e.z   = amul(bus.req_x[g], bus.req_y[g]);
                e.sat = is_sat(e.z);
                q.push_back(e);
                gnt_log.push_back(g);
                last_grant = g;
                acc = 1;
            end
        end
        prev_stall = bus.rsp_valid && !bus.rsp_ready;
        prev_z     = bus.rsp_z;
        prev_id    = int'(bus.rsp_id);
        @(posedge clk);
        #1;
        if (auto_drop && acc) bus.req_valid[g] = 1'b0;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            bus.req_x[i] = $urandom;
            bus.req_y[i] = $urandom;
        end
    endtask

    initial begin
        int start;
        int c;
        int cnt0;
        int hs;
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.rsp_ready  = 1'b1;
        bus2.req_valid = '0;
        bus2.req_x     = '0;
        bus2.req_y     = '0;
        bus2.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_z", bus.rsp_z, 32'd0);
        chk("rst_mul_x", bus.mul_x, 32'd0);
        chk("rst_mul_y", bus.mul_y, 32'd0);
        chk("rst_rsp_sat", 32'(bus.rsp_sat), 32'd0);
        chk("rst_sat_count", 32'(bus.sat_count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single request, 2-cycle latency
        bus.req_x[0] = 32'h3FC00000;
        bus.req_y[0] = 32'h40000000;
        bus.req_valid[0] = 1'b1;
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid[0] = 1'b0;
        #1;
        chk("t1_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_mul_x", bus.mul_x, 32'h3FC00000);
        chk("t1_mul_y", bus.mul_y, 32'h40000000);
        step();
        #1;
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("t1_rsp_z", bus.rsp_z, 32'h40400000);
        chk("t1_rsp_sat", 32'(bus.rsp_sat), 32'd0);
        step();
        #1;
        chk("t1_idle_busy", 32'(bus.busy), 32'd0);

        // round robin, full throughput
        rand_ops();
        start = (last_grant + 1) % NR;
        gnt_log.delete();
        bus.req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i >= 1) chk("rr_nogap", 32'(bus.rsp_valid), 32'd1);
        end
        for (int k = 0; k < 8 && k < gnt_log.size(); k++)
            chk("rr_seq", 32'(gnt_log[k]), 32'((start + k) % NR));
        bus.req_valid[1] = 1'b0;
        gnt_log.delete();
        c = last_grant;
        for (int i = 0; i < 6; i++) step();
        chk("rr_skip_cnt", 32'(gnt_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < gnt_log.size(); k++) begin
            c = (c + 1) % NR;
            if (c == 1) c = 2;
            chk("rr_skip_seq", 32'(gnt_log[k]), 32'(c));
        end
        drain();

        // backpressure
        rand_ops();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1101;
        auto_drop = 1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            step();
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
            step();
        end
        auto_drop = 0;
        drain();

        // saturation flag and counter
        cnt0 = exp_cnt;
        bus.req_x[0] = 32'h7F000000;
        bus.req_y[0] = 32'h7F000000;
        bus.req_valid[0] = 1'b1;
        bus.rsp_ready = 1'b0;
        auto_drop = 1;
        step();
        step();
        chk("sat_flag", 32'(bus.rsp_sat), 32'd1);
        chk("sat_z", bus.rsp_z, 32'h7F7FFFFF);
        step();
        chk("sat_no_inc_stall", 32'(bus.sat_count), 32'(cnt0));
        bus.rsp_ready = 1'b1;
        step();
        chk("sat_inc", 32'(bus.sat_count), 32'(cnt0 + 1));
        auto_drop = 0;
        drain();

        // counter clamp on a narrow instance
        bus2.req_x[0] = 32'h7F000000;
        bus2.req_y[0] = 32'h7F000000;
        bus2.req_valid = 2'b01;
        hs = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("sat3_count", 32'(bus2.sat_count), 32'((hs > 7) ? 7 : hs));
            if (bus2.rsp_valid && bus2.rsp_ready) hs++;
            @(posedge clk);
            #1;
        end
        bus2.req_valid = '0;
        chk("sat3_clamped", 32'(bus2.sat_count), 32'd7);

        // mid-operation reset
        rand_ops();
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        step();
        step();
        chk("mr_full_valid", 32'(bus.rsp_valid), 32'd1);
        chk("mr_full_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_req_ready", 32'(bus.req_ready), 32'd0);
        chk("mr_mul_x", bus.mul_x, 32'd0);
        chk("mr_rsp_z", bus.rsp_z, 32'd0);
        q.delete();
        last_grant = NR - 1;
        exp_cnt    = 0;
        prev_stall = 0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_no_stale", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid = '1;
        #1;
        chk("mr_grant0", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) step();
        drain();

        // idle keeps the pointer
        bus.req_valid = '0;
        for (int i = 0; i < 10; i++) step();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rand_ops();
        bus.req_valid = '1;
        #1;
        chk("idle_next_grant", 32'(bus.req_ready), 32'd1 << ((last_grant + 1) % NR));
        step();
        drain();

        // random traffic against the scoreboard
        for (int n = 0; n < 400; n++) begin
            bus.rsp_ready = ($urandom_range(3, 0) != 0);
            bus.req_valid = 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(7, 0) == 0) begin
                    bus.req_x[i] = 32'h7F000000 | ($urandom & 32'h807FFFFF);
                    bus.req_y[i] = 32'h7F000000 | ($urandom & 32'h007FFFFF);
                end else begin
                    bus.req_x[i] = $urandom;
                    bus.req_y[i] = $urandom;
                end
            end
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one combinational single-precision approximate multiplier datapath between NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels; the multiplier sits between two register stages.
- Returns each result, tagged with the requester index, on a single shared response channel with backpressure.
- Also flags saturated (overflow-clamped) results and counts them for error-characterisation runs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; must equal max(1, clog2(NUM_REQ)).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid and ready are both high.
- req_x  in  32*NUM_REQ  operand X per requester, {sign,exp[7:0],mant[22:0]}; requester i occupies bits [32i+31:32i].
- req_y  in  32*NUM_REQ  operand Y, same packing as req_x.
- mul_x  out  32  registered operand X to the external multiplier.
- mul_y  out  32  registered operand Y to the external multiplier.
- mul_z  in  32  combinational multiplier result {sign,exp,mant}.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_z  out  32  product.
- rsp_sat  out  1  rsp_z exponent is 8'hFE and its mantissa is all ones (clamped overflow).
- sat_count  out  CNT_W  number of accepted saturated responses; saturates at all-ones.
- busy  out  1  S1 or S2 holds a valid entry.

Behaviour:
- Reset (async, immediate): all stage valids 0; req_ready=0; rsp_valid=0; rsp_id=0; rsp_z=0; mul_x=mul_y=0; rsp_sat=0; sat_count=0; busy=0; rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
- Pipeline stage S1 holds {v1,id1,x1,y1}. mul_x=x1 and mul_y=y1.
- Pipeline stage S2 holds {v2,id2,z2,sat2}. It drives rsp_valid=v2, rsp_id=id2, rsp_z=z2, rsp_sat=sat2.
- adv2 = !v2 | rsp_ready. adv1 = adv2 | !v1.
- Arbitration (combinational each cycle):
  - When adv1=1, grant goes to the first requester with req_valid=1, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Only the granted requester sees req_ready=1. When adv1=0, all req_ready=0.
  - req_ready never depends on any req_valid other than the requester's own arbitration result; no ready without a corresponding grant.
- On a grant at clock edge N:
  - S1 loads that requester's operands and id; rr_ptr takes the granted index.
  - If no requester is valid, S1 loads v1=0 (when adv1=1) and rr_ptr is unchanged.
- On an adv2 edge:
  - S2 loads v2=v1, id2=id1, z2=mul_z.
  - sat2 = v1 & (mul_z[30:23]==8'hFE) & (&mul_z[22:0]).
- When adv2=0, S1 and S2 hold all fields and mul_x/mul_y stay stable.
- Latency: request accepted at edge N → rsp_valid at edge N+1 settles after S1, i.e. the response is presented in the cycle following edge N+1. That is 2 cycles from acceptance, with no stall.
- Throughput: 1 result per cycle while rsp_ready=1.
- sat_count increments on each rsp_valid & rsp_ready & rsp_sat, and holds at 2^CNT_W-1.
- Ordering: responses leave in grant order. No reordering and no drops.
- Simultaneous events: the edge that pops S2 (rsp_ready=1) may also shift S1→S2 and load a new grant into S1. This is full-throughput operation with no bubble.
- Backpressure: rsp_ready held low with both stages full gives req_ready=0 for every requester. Nothing is lost, and rsp_z/rsp_id remain constant until accepted.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- A requester that drops req_valid is skipped with no penalty cycle.
- rst asserted mid-operation discards in-flight entries; there is no response for them.

Test Plan:
- Single request: after reset, req0 valid with x=0x3FC00000 (1.5), y=0x40000000 (2.0), model returns 0x40400000 → req_ready[0]=1 for one cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_z=0x40400000, rsp_sat=0.
- Round-robin: all 4 requesters continuously valid, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1,2,3, one per cycle with no gaps. Then drop req_valid[1] → sequence 0,2,3,0.
- Backpressure: 3 requests accepted, then rsp_ready=0 for 5 cycles → rsp_valid stays 1 with rsp_id/rsp_z unchanged, req_ready all 0. Releasing rsp_ready delivers the three responses on consecutive cycles in order.
- Saturation: mul_z=0x7F7FFFFF on a valid entry → rsp_sat=1; sat_count increments by 1 only on the handshake cycle. Preload sat_count to 0xFFFF with CNT_W=16 → it stays 0xFFFF.
- Mid-operation reset: rst pulsed asynchronously while S1 and S2 are full → outputs clear immediately, no stale response after release, and the next grant goes to requester 0.
- Idle: no req_valid for 10 cycles → busy=0, rsp_valid=0, rr_ptr unchanged (the next grant follows the last grant index).
